pipe_hazard_int_ctrl: RTL and testbench

Central stall/flush and interrupt-entry sequencer for the 5-stage interrupt-capable CPU. It drives the Stall/Flush inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves memory-wait, load-use and taken-branch hazards. It also sequences interrupt entry (drain, then redirect to the vector) and ERET return via a PC-source select.

---
 rtl/pipe_hazard_int_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_int_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_int_ctrl.sv
// Stall/flush and interrupt-entry sequencer for the 5-stage pipeline.
// Resolves memory-wait, load-use and taken-branch hazards, drains the back
// end of the pipe before redirecting to the interrupt vector, and handles
// ERET through the PC-source select.
//
// Each cycle the block decides from the current inputs and state. The
// priority order is:
//   1. memory wait
//   2. load-use
//   3. ERET
//   4. interrupt accept
//   5. branch
// Every Stall/Flush output is a single-cycle level. The stage that owns a
// register samples it on the same rising edge.
// There is no handshake. int_req is a level and is sampled only in RUN.
module pipe_hazard_int_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [31:0] ID_PC,
    input  logic        ID_eret,
    input  logic        ID_branch_taken,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    input  logic        int_req,
    output logic        PC_Stall,
    output logic        IF_ID_Stall,
    output logic        ID_EX_Stall,
    output logic        EX_MEM_Stall,
    output logic        MEM_WB_Stall,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Flush,
    output logic        MEM_WB_Flush,
    output logic [1:0]  pc_sel,
    output logic [31:0] int_vec,
    output logic [31:0] epc,
    output logic        int_en,
    output logic        int_ack,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_VECTOR = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] epc_next;
    logic        int_en_next;
    logic        memwait;
    logic        loaduse;

    assign memwait   = MEM_req & ~MEM_ready;
    assign loaduse   = EX_MemRead & (EX_rt != 5'd0) & ((EX_rt == ID_rs) | (EX_rt == ID_rt));
    assign int_vec   = INT_VECTOR;
    assign state_dbg = state;

    // Next-state and stall/flush decode; reset forces every control output low.
    always_comb begin
        PC_Stall     = 1'b0;
        IF_ID_Stall  = 1'b0;
        ID_EX_Stall  = 1'b0;
        EX_MEM_Stall = 1'b0;
        MEM_WB_Stall = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        pc_sel       = 2'b00;
        int_ack      = 1'b0;
        state_next   = state;
        cnt_next     = cnt;
        epc_next     = epc;
        int_en_next  = int_en;
        if (!reset) begin
            if (memwait) begin
                // Hold everything up to EX/MEM and bubble into MEM/WB.
                // The FSM is frozen.
                PC_Stall     = 1'b1;
                IF_ID_Stall  = 1'b1;
                ID_EX_Stall  = 1'b1;
                EX_MEM_Stall = 1'b1;
                MEM_WB_Flush = 1'b1;
            end else begin
                case (state)
                    S_RUN: begin
                        if (loaduse) begin
                            PC_Stall    = 1'b1;
                            IF_ID_Stall = 1'b1;
                            ID_EX_Flush = 1'b1;
                        end else if (ID_eret) begin
                            pc_sel      = 2'b10;
                            IF_ID_Flush = 1'b1;
                            int_en_next = 1'b1;
                        end else if (int_req && int_en) begin
                            // The ID instruction is squashed and saved as the
                            // return PC. The PC is held so that a taken branch
                            // in ID cannot redirect the fetch.
                            PC_Stall    = 1'b1;
                            IF_ID_Flush = 1'b1;
                            ID_EX_Flush = 1'b1;
                            state_next  = S_DRAIN;
                            epc_next    = ID_PC;
                            int_en_next = 1'b0;
                            cnt_next    = CNT_LOAD;
                        end else if (ID_branch_taken) begin
                            IF_ID_Flush = 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        PC_Stall    = 1'b1;
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                        if (cnt == 4'd0) begin
                            state_next = S_VECTOR;
                        end else begin
                            cnt_next = cnt - 4'd1;
                        end
                    end
                    S_VECTOR: begin
                        pc_sel      = 2'b01;
                        int_ack     = 1'b1;
                        IF_ID_Flush = 1'b1;
                        state_next  = S_RUN;
                    end
                    default: begin
                        state_next = S_RUN;
                    end
                endcase
            end
        end
    end

    // State, drain counter, return PC and interrupt enable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_RUN;
            cnt    <= 4'd0;
            epc    <= 32'd0;
            int_en <= 1'b1;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            epc    <= epc_next;
            int_en <= int_en_next;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_int_ctrl.sv
// Directed bench for pipe_hazard_int_ctrl.
// Each step drives inputs just after a rising edge and queues the expected
// control outputs and registered state. A monitor samples on the falling edge
// and compares against the head of the queue.
module tb_pipe_hazard_int_ctrl;

    localparam logic [8:0] SF_NONE = 9'b000000000;
    localparam logic [8:0] SF_MW   = 9'b111100001;
    localparam logic [8:0] SF_LU   = 9'b110000100;
    localparam logic [8:0] SF_BR   = 9'b000001000;
    localparam logic [8:0] SF_DR   = 9'b100001100;
    localparam logic [1:0] R = 2'd0, D = 2'd1, V = 2'd2;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic [31:0] ID_PC;
    logic        ID_eret, ID_branch_taken, EX_MemRead, MEM_req, MEM_ready, int_req;
    logic        PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall;
    logic        IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
    logic [1:0]  pc_sel;
    logic [31:0] int_vec, epc;
    logic        int_en, int_ack;
    logic [1:0]  state_dbg;

    logic [46:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    pipe_hazard_int_ctrl #(.DRAIN_CYCLES(3), .INT_VECTOR(32'h0000_0004)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_PC(ID_PC), .ID_eret(ID_eret),
        .ID_branch_taken(ID_branch_taken), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready), .int_req(int_req),
        .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
        .EX_MEM_Stall(EX_MEM_Stall), .MEM_WB_Stall(MEM_WB_Stall),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Flush(EX_MEM_Flush), .MEM_WB_Flush(MEM_WB_Flush),
        .pc_sel(pc_sel), .int_vec(int_vec), .epc(epc), .int_en(int_en),
        .int_ack(int_ack), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0; ID_PC = 32'd0;
        ID_eret = 1'b0; ID_branch_taken = 1'b0; EX_MemRead = 1'b0;
        MEM_req = 1'b0; MEM_ready = 1'b0; int_req = 1'b0;
    endtask

    task automatic step(input string nm, input logic [8:0] sf, input logic [1:0] ps,
                        input logic ack, input logic ien, input logic [31:0] e,
                        input logic [1:0] st);
        exp_q.push_back({sf, ps, ack, ien, e, st});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one comparison per queued cycle
    initial begin
        logic [46:0] exp_v;
        logic [46:0] act_v;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, MEM_WB_Stall,
                         IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
                         pc_sel, int_ack, int_en, epc, state_dbg};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_err++;
                    $display("FAIL %s: got sf=%b pc_sel=%b ack=%b en=%b epc=%h st=%0d, want sf=%b pc_sel=%b ack=%b en=%b epc=%h st=%0d",
                             nm, act_v[46:38], act_v[37:36], act_v[35], act_v[34], act_v[33:2], act_v[1:0],
                             exp_v[46:38], exp_v[37:36], exp_v[35], exp_v[34], exp_v[33:2], exp_v[1:0]);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Outputs forced low while reset is high, even with hazards present
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        MEM_req = 1'b1; MEM_ready = 1'b0; int_req = 1'b1;
        step("reset_hold", SF_NONE, 2'b00, 0, 1, 32'd0, R);
        reset = 1'b0;

        // Load-use
        idle(); EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        step("lu_rs", SF_LU, 2'b00, 0, 1, 32'd0, R);
        idle(); EX_MemRead = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
        step("lu_rt_zero", SF_NONE, 2'b00, 0, 1, 32'd0, R);
        idle(); EX_MemRead = 1'b1; EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3;
        step("lu_rt", SF_LU, 2'b00, 0, 1, 32'd0, R);
        idle(); EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd6; ID_rt = 5'd4;
        step("lu_nomatch", SF_NONE, 2'b00, 0, 1, 32'd0, R);
        idle(); EX_MemRead = 1'b0; EX_rt = 5'd5; ID_rs = 5'd5;
        step("lu_noload", SF_NONE, 2'b00, 0, 1, 32'd0, R);

        // Branch alone, then suppressed by load-use
        idle(); ID_branch_taken = 1'b1;
        step("branch", SF_BR, 2'b00, 0, 1, 32'd0, R);
        EX_MemRead = 1'b1; EX_rt = 5'd9; ID_rs = 5'd9;
        step("branch_lu", SF_LU, 2'b00, 0, 1, 32'd0, R);

        // Memory wait with coincident load-use and branch
        MEM_req = 1'b1; MEM_ready = 1'b0;
        step("memwait1", SF_MW, 2'b00, 0, 1, 32'd0, R);
        step("memwait2", SF_MW, 2'b00, 0, 1, 32'd0, R);
        step("memwait3", SF_MW, 2'b00, 0, 1, 32'd0, R);
        MEM_ready = 1'b1;
        step("memwait_done", SF_LU, 2'b00, 0, 1, 32'd0, R);

        // Interrupt entry
        idle(); int_req = 1'b1; ID_PC = 32'h0000_0040;
        step("int_accept", SF_DR, 2'b00, 0, 1, 32'd0, R);
        idle(); ID_branch_taken = 1'b1; EX_MemRead = 1'b1; EX_rt = 5'd2; ID_rs = 5'd2;
        step("drain1", SF_DR, 2'b00, 0, 0, 32'h40, D);
        idle();
        step("drain2", SF_DR, 2'b00, 0, 0, 32'h40, D);
        step("drain3", SF_DR, 2'b00, 0, 0, 32'h40, D);
        ID_branch_taken = 1'b1;
        step("vector", SF_BR, 2'b01, 1, 0, 32'h40, V);
        idle(); int_req = 1'b1;
        step("nested_blocked", SF_NONE, 2'b00, 0, 0, 32'h40, R);

        // ERET with int_en low and int_req held
        ID_eret = 1'b1;
        step("eret", SF_BR, 2'b10, 0, 0, 32'h40, R);
        ID_eret = 1'b0; ID_PC = 32'h0000_0080;
        step("int_after_eret", SF_DR, 2'b00, 0, 1, 32'h40, R);

        // Memory wait mid-drain stretches the drain
        idle(); MEM_req = 1'b1; MEM_ready = 1'b0;
        step("drain_mw1", SF_MW, 2'b00, 0, 0, 32'h80, D);
        step("drain_mw2", SF_MW, 2'b00, 0, 0, 32'h80, D);
        idle();
        step("drain_b1", SF_DR, 2'b00, 0, 0, 32'h80, D);
        step("drain_b2", SF_DR, 2'b00, 0, 0, 32'h80, D);
        step("drain_b3", SF_DR, 2'b00, 0, 0, 32'h80, D);
        step("vector_b", SF_BR, 2'b01, 1, 0, 32'h80, V);
        step("run_b", SF_NONE, 2'b00, 0, 0, 32'h80, R);
        ID_eret = 1'b1;
        step("eret_b", SF_BR, 2'b10, 0, 0, 32'h80, R);
        idle();
        step("int_en_back", SF_NONE, 2'b00, 0, 1, 32'h80, R);

        // ERET wins over a simultaneous interrupt
        ID_eret = 1'b1; int_req = 1'b1;
        step("eret_prio", SF_BR, 2'b10, 0, 1, 32'h80, R);

        // Interrupt deferred by memory wait
        ID_eret = 1'b0; ID_PC = 32'h0000_0100; MEM_req = 1'b1; MEM_ready = 1'b0;
        step("int_mw1", SF_MW, 2'b00, 0, 1, 32'h80, R);
        step("int_mw2", SF_MW, 2'b00, 0, 1, 32'h80, R);
        MEM_ready = 1'b1;
        step("int_mw_accept", SF_DR, 2'b00, 0, 1, 32'h80, R);

        // Reset in the second drain cycle abandons the sequence
        idle();
        step("drain_c1", SF_DR, 2'b00, 0, 0, 32'h100, D);
        reset = 1'b1;
        step("reset_mid", SF_NONE, 2'b00, 0, 0, 32'h100, D);
        reset = 1'b0;
        step("after_reset1", SF_NONE, 2'b00, 0, 1, 32'd0, R);
        step("after_reset2", SF_NONE, 2'b00, 0, 1, 32'd0, R);

        // Let the monitor empty the queue, within a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_queue: got %0d entries left, want 0", exp_q.size());
        end

        n_cmp++;
        if (int_vec !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL int_vec: got %h, want 00000004", int_vec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
